mdu: RTL and testbench

MDU -- requirements
Module: mdu

---
 rtl/mdu.sv | 168 ++++++++++++++++
 tb/tb_mdu.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// Iterative MIPS multiply/divide unit with HI/LO registers; 32 RUN cycles per operation.
// Define MDU_FAST_MUL_EN to make MULT/MULTU complete in a single cycle from IDLE.
module mdu (
    input  logic        clk,
    input  logic        reset,
    input  logic        startE,
    input  logic [1:0]  opE,
    input  logic [31:0] srcaE,
    input  logic [31:0] srcbE,
    input  logic        abortE,
    input  logic        hiwriteW,
    input  logic        lowriteW,
    input  logic [31:0] wdataW,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [63:0] work_q, work_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    // Operand magnitudes of the latched operation; sign is reapplied on completion.
    logic        neg_a, neg_b;
    logic [31:0] mag_a, mag_b;
    logic [32:0] mul_sum;
    logic [63:0] mul_nx;
    logic [32:0] rem_sh;
    logic [31:0] div_diff;
    logic        div_ge;
    logic [63:0] div_nx;
    logic [63:0] step_nx;
    logic [63:0] mul_res;
    logic [31:0] quo_res, rem_res;

    // Magnitudes of the incoming operands, used to seed the work register.
    logic        s_neg_a, s_neg_b;
    logic [31:0] s_mag_a, s_mag_b;
    logic        start_ok;
    logic        go_run;
`ifdef MDU_FAST_MUL_EN
    logic        fast_hit;
    logic [63:0] ext_a, ext_b, fast_prod;
`endif

    assign neg_a   = ~op_q[0] & a_q[31];
    assign neg_b   = ~op_q[0] & b_q[31];
    assign mag_a   = neg_a ? -a_q : a_q;
    assign mag_b   = neg_b ? -b_q : b_q;

    // Shift-add: multiplier sits in the low half and is consumed LSB first.
    assign mul_sum = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, mag_a} : 33'd0);
    assign mul_nx  = {mul_sum, work_q[31:1]};

    // Restoring division: {remainder, quotient} shifts left one bit per step.
    assign rem_sh   = work_q[63:31];
    assign div_ge   = (rem_sh >= {1'b0, mag_b});
    assign div_diff = rem_sh[31:0] - mag_b;
    assign div_nx   = div_ge ? {div_diff, work_q[30:0], 1'b1} : {work_q[62:0], 1'b0};

    assign step_nx  = op_q[1] ? div_nx : mul_nx;
    assign mul_res  = (neg_a ^ neg_b) ? -step_nx : step_nx;
    assign quo_res  = (neg_a ^ neg_b) ? -step_nx[31:0] : step_nx[31:0];
    assign rem_res  = neg_a ? -step_nx[63:32] : step_nx[63:32];

    assign s_neg_a  = ~opE[0] & srcaE[31];
    assign s_neg_b  = ~opE[0] & srcbE[31];
    assign s_mag_a  = s_neg_a ? -srcaE : srcaE;
    assign s_mag_b  = s_neg_b ? -srcbE : srcbE;
    assign start_ok = startE & ~abortE;

`ifdef MDU_FAST_MUL_EN
    assign ext_a     = opE[0] ? {32'd0, srcaE} : {{32{srcaE[31]}}, srcaE};
    assign ext_b     = opE[0] ? {32'd0, srcbE} : {{32{srcbE[31]}}, srcbE};
    assign fast_prod = ext_a * ext_b;
    assign fast_hit  = start_ok & ~opE[1];
    assign go_run    = start_ok & opE[1];
`else
    assign go_run    = start_ok;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        work_d  = work_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (hiwriteW) hi_d = wdataW;
                if (lowriteW) lo_d = wdataW;
`ifdef MDU_FAST_MUL_EN
                if (fast_hit) begin
                    hi_d = fast_prod[63:32];
                    lo_d = fast_prod[31:0];
                end
`endif
                if (go_run) begin
                    state_d = RUN;
                    cnt_d   = 5'd0;
                    op_d    = opE;
                    a_d     = srcaE;
                    b_d     = srcbE;
                    work_d  = opE[1] ? {32'd0, s_mag_a} : {32'd0, s_mag_b};
                end
            end
            RUN: begin
                if (abortE) begin
                    state_d = IDLE;
                end else begin
                    work_d = step_nx;
                    cnt_d  = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = IDLE;
                        if (!op_q[1]) begin
                            hi_d = mul_res[63:32];
                            lo_d = mul_res[31:0];
                        end else if (b_q == 32'd0) begin
                            hi_d = a_q;
                            lo_d = 32'hFFFF_FFFF;
                        end else begin
                            hi_d = rem_res;
                            lo_d = quo_res;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            op_q    <= 2'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            work_q  <= 64'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            work_q  <= work_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q == RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Randomized and directed checks of mdu against an arithmetic reference model.
module tb_mdu;

`ifdef MDU_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        startE;
    logic [1:0]  opE;
    logic [31:0] srcaE, srcbE;
    logic        abortE;
    logic        hiwriteW, lowriteW;
    logic [31:0] wdataW;
    logic        busy;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    mdu dut (
        .clk(clk), .reset(reset), .startE(startE), .opE(opE),
        .srcaE(srcaE), .srcbE(srcbE), .abortE(abortE),
        .hiwriteW(hiwriteW), .lowriteW(lowriteW), .wdataW(wdataW),
        .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected {hi, lo} straight from the arithmetic definition of each opcode.
    function automatic logic [63:0] ref_calc(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'd0: res = sa * sb;
            2'd1: res = {32'd0, a} * {32'd0, b};
            2'd2: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else res = {a % b, a / b};
            end
        endcase
        return res;
    endfunction

    function automatic int exp_cycles(input logic [1:0] op);
        return (FAST && !op[1]) ? 0 : 32;
    endfunction

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        startE = 1'b1; opE = op; srcaE = a; srcbE = b;
        @(negedge clk);
        startE = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        logic [63:0] e;
        issue(op, a, b);
        wait_done(n);
        e = ref_calc(op, a, b);
        chk({tag, "_cycles"}, 64'(n), 64'(exp_cycles(op)));
        chk({tag, "_hi"}, {32'd0, hi}, {32'd0, e[63:32]});
        chk({tag, "_lo"}, {32'd0, lo}, {32'd0, e[31:0]});
        model_hi = e[63:32];
        model_lo = e[31:0];
    endtask

    task automatic mt_write(input logic hw, input logic lw, input logic [31:0] d);
        hiwriteW = hw; lowriteW = lw; wdataW = d;
        @(negedge clk);
        hiwriteW = 1'b0; lowriteW = 1'b0;
        if (hw) model_hi = d;
        if (lw) model_lo = d;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'd0;
            3: return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        int n;
        logic [63:0] e;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        reset = 1'b1; startE = 1'b0; opE = 2'd0; srcaE = 32'd0; srcbE = 32'd0;
        abortE = 1'b0; hiwriteW = 1'b0; lowriteW = 1'b0; wdataW = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_hi", {32'd0, hi}, 64'd0);
        chk("reset_lo", {32'd0, lo}, 64'd0);

        run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_max_hi_lit", {32'd0, hi}, 64'h0000_0000_FFFF_FFFE);
        run_op("mult_neg", 2'd0, 32'hFFFF_FFFE, 32'd3);
        chk("mult_neg_lo_lit", {32'd0, lo}, 64'h0000_0000_FFFF_FFFA);
        run_op("div_neg7", 2'd2, 32'hFFFF_FFF9, 32'd2);
        chk("div_neg7_lo_lit", {32'd0, lo}, 64'h0000_0000_FFFF_FFFD);
        run_op("divu_zero", 2'd3, 32'd7, 32'd0);
        run_op("div_zero", 2'd2, 32'hFFFF_FFF0, 32'd0);
        run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf_lo_lit", {32'd0, lo}, 64'h0000_0000_8000_0000);

        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra = pick();
            rb = pick();
            run_op("rand", rop, ra, rb);
        end

        // A second start mid-RUN must not disturb the running divide.
        issue(2'd3, 32'd100, 32'd7);
        repeat (2) @(negedge clk);
        startE = 1'b1; opE = 2'd1; srcaE = 32'd5; srcbE = 32'd5;
        @(negedge clk);
        startE = 1'b0;
        wait_done(n);
        chk("restart_cycles", 64'(n + 3), 64'd32);
        chk("restart_hi", {32'd0, hi}, 64'd2);
        chk("restart_lo", {32'd0, lo}, 64'd14);
        model_hi = 32'd2; model_lo = 32'd14;

        // Abort on the final RUN cycle beats the write-back.
        issue(2'd2, 32'd1000, 32'd3);
        repeat (4) @(negedge clk);
        startE = 1'b1; opE = 2'd3; srcaE = 32'd9; srcbE = 32'd2;
        @(negedge clk);
        startE = 1'b0;
        repeat (26) @(negedge clk);
        chk("abort32_busy_before", {63'd0, busy}, 64'd1);
        abortE = 1'b1;
        @(negedge clk);
        abortE = 1'b0;
        chk("abort32_busy", {63'd0, busy}, 64'd0);
        chk("abort32_hi", {32'd0, hi}, {32'd0, model_hi});
        chk("abort32_lo", {32'd0, lo}, {32'd0, model_lo});
        @(negedge clk);
        chk("abort32_busy_later", {63'd0, busy}, 64'd0);
        chk("abort32_lo_later", {32'd0, lo}, {32'd0, model_lo});

        // Abort mid-run, then abort coinciding with start in IDLE.
        issue(2'd3, 32'd77, 32'd5);
        repeat (9) @(negedge clk);
        abortE = 1'b1;
        @(negedge clk);
        abortE = 1'b0;
        chk("abort_mid_busy", {63'd0, busy}, 64'd0);
        chk("abort_mid_hi", {32'd0, hi}, {32'd0, model_hi});
        abortE = 1'b1; startE = 1'b1; opE = 2'd3; srcaE = 32'd8; srcbE = 32'd3;
        @(negedge clk);
        abortE = 1'b0; startE = 1'b0;
        chk("abort_start_busy", {63'd0, busy}, 64'd0);
        chk("abort_start_lo", {32'd0, lo}, {32'd0, model_lo});

        // MTHI/MTLO in IDLE.
        mt_write(1'b1, 1'b1, 32'hCAFE_F00D);
        chk("mt_both_hi", {32'd0, hi}, {32'd0, model_hi});
        chk("mt_both_lo", {32'd0, lo}, {32'd0, model_lo});
        mt_write(1'b0, 1'b1, 32'h0BAD_0BAD);
        chk("mtlo_hi", {32'd0, hi}, 64'h0000_0000_CAFE_F00D);
        chk("mtlo_lo", {32'd0, lo}, 64'h0000_0000_0BAD_0BAD);

        // MTHI together with a start: write lands, then the result overwrites it.
        hiwriteW = 1'b1; wdataW = 32'hDEAD_BEEF;
        issue(2'd3, 32'd50, 32'd6);
        hiwriteW = 1'b0;
        chk("mt_start_hi_early", {32'd0, hi}, 64'h0000_0000_DEAD_BEEF);
        wait_done(n);
        chk("mt_start_cycles", 64'(n), 64'd32);
        chk("mt_start_hi", {32'd0, hi}, 64'd2);
        chk("mt_start_lo", {32'd0, lo}, 64'd8);

        // MTHI/MTLO during RUN are ignored.
        issue(2'd3, 32'd99, 32'd10);
        hiwriteW = 1'b1; lowriteW = 1'b1; wdataW = 32'h5555_5555;
        @(negedge clk);
        hiwriteW = 1'b0; lowriteW = 1'b0;
        chk("mt_run_lo_hold", {32'd0, lo}, 64'd8);
        wait_done(n);
        chk("mt_run_cycles", 64'(n + 1), 64'd32);
        chk("mt_run_hi", {32'd0, hi}, 64'd9);
        chk("mt_run_lo", {32'd0, lo}, 64'd9);

        // Reset in the middle of a divide clears everything.
        mt_write(1'b1, 1'b0, 32'h1234_5678);
        mt_write(1'b0, 1'b1, 32'h9ABC_DEF0);
        chk("mt_pre_hi", {32'd0, hi}, 64'h0000_0000_1234_5678);
        chk("mt_pre_lo", {32'd0, lo}, 64'h0000_0000_9ABC_DEF0);
        issue(2'd3, 32'd1234, 32'd5);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_run_busy", {63'd0, busy}, 64'd0);
        chk("rst_run_hi", {32'd0, hi}, 64'd0);
        chk("rst_run_lo", {32'd0, lo}, 64'd0);
        model_hi = 32'd0; model_lo = 32'd0;

        run_op("post_reset", 2'd2, 32'd1234, 32'hFFFF_FFFB);
        e = ref_calc(2'd0, 32'h7FFF_FFFF, 32'h8000_0000);
        run_op("mult_corner", 2'd0, 32'h7FFF_FFFF, 32'h8000_0000);
        chk("mult_corner_full", {hi, lo}, e);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
